// File: rtl/repair_sb_arbiter_if.sv
// ---------------------------------------------------------------------------
// repair_sb_arbiter_if
// Bundles the REPAIR requester handshakes and the sideband encoder channel
// that the arbiter sits between.
//
// Signals:
//   i_en                     REPAIR substate enable (low = abort to IDLE)
//   i_req_tx/i_msg_tx/i_data_tx  tx-side request, 4-bit message, 3-bit lanes
//   i_req_rx/i_msg_rx/i_data_rx  rx-side request, 4-bit message, 3-bit lanes
//   i_sb_busy                sideband encoder busy
//   o_sb_valid/o_sb_message/o_sb_data  granted message toward the sideband
//   o_gnt_tx/o_gnt_rx        which requester currently owns the channel
//   o_done_tx/o_done_rx      one-cycle completion pulse to the winner
//   o_timeout                one-cycle pulse: busy never rose
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the sideband outputs)
//   master - the surrounding environment (requesters plus sideband encoder)
// ---------------------------------------------------------------------------
interface repair_sb_arbiter_if;
  logic       i_en;
  logic       i_req_tx;
  logic [3:0] i_msg_tx;
  logic [2:0] i_data_tx;
  logic       i_req_rx;
  logic [3:0] i_msg_rx;
  logic [2:0] i_data_rx;
  logic       i_sb_busy;
  logic       o_sb_valid;
  logic [3:0] o_sb_message;
  logic [2:0] o_sb_data;
  logic       o_gnt_tx;
  logic       o_gnt_rx;
  logic       o_done_tx;
  logic       o_done_rx;
  logic       o_timeout;

  modport slave (
    input  i_en, i_req_tx, i_msg_tx, i_data_tx,
    input  i_req_rx, i_msg_rx, i_data_rx, i_sb_busy,
    output o_sb_valid, o_sb_message, o_sb_data,
    output o_gnt_tx, o_gnt_rx, o_done_tx, o_done_rx, o_timeout
  );

  modport master (
    output i_en, i_req_tx, i_msg_tx, i_data_tx,
    output i_req_rx, i_msg_rx, i_data_rx, i_sb_busy,
    input  o_sb_valid, o_sb_message, o_sb_data,
    input  o_gnt_tx, o_gnt_rx, o_done_tx, o_done_rx, o_timeout
  );
endinterface

// File: rtl/repair_sb_arbiter.sv
// ---------------------------------------------------------------------------
// repair_sb_arbiter
// Shares the single MBTRAIN sideband transmit channel between the REPAIR
// tx-side and rx-side sequencers. Round-robin grant, the winning message is
// latched and held until the sideband finishes it (busy falling edge), the
// winner gets a one-cycle done pulse, then an idle gap precedes the next
// grant. If busy never rises the grant is aborted with a timeout pulse.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   sb   - repair_sb_arbiter_if.slave (requests in, sideband/grant/done out)
//
// Parameters:
//   GAP_CYCLES     - idle cycles after each completion (0 = no gap state)
//   TIMEOUT_CYCLES - ISSUE cycles allowed before busy must rise
//   CNT_W          - counter width, holds max(GAP_CYCLES, TIMEOUT_CYCLES)
// ---------------------------------------------------------------------------
module repair_sb_arbiter #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  repair_sb_arbiter_if.slave   sb
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 32'd1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_q_r;
  logic             last_tx_r, last_tx_s;    // 1 = tx owned the last grant
  logic             sb_valid_r, sb_valid_s;
  logic [3:0]       sb_message_r, sb_message_s;
  logic [2:0]       sb_data_r, sb_data_s;
  logic             gnt_tx_r, gnt_tx_s;
  logic             gnt_rx_r, gnt_rx_s;
  logic             done_tx_r, done_tx_s;
  logic             done_rx_r, done_rx_s;
  logic             timeout_r, timeout_s;
  logic             busy_fall_s;
  logic             pick_tx_s;

  assign busy_fall_s = busy_q_r & ~sb.i_sb_busy;
  // tx wins when it is alone, or on a tie when rx held the previous grant.
  assign pick_tx_s   = sb.i_req_tx & (~sb.i_req_rx | ~last_tx_r);

  // State, counter, busy delay, round-robin pointer and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      busy_q_r     <= 1'b0;
      last_tx_r    <= 1'b0;
      sb_valid_r   <= 1'b0;
      sb_message_r <= 4'd0;
      sb_data_r    <= 3'd0;
      gnt_tx_r     <= 1'b0;
      gnt_rx_r     <= 1'b0;
      done_tx_r    <= 1'b0;
      done_rx_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      busy_q_r     <= sb.i_sb_busy;
      last_tx_r    <= last_tx_s;
      sb_valid_r   <= sb_valid_s;
      sb_message_r <= sb_message_s;
      sb_data_r    <= sb_data_s;
      gnt_tx_r     <= gnt_tx_s;
      gnt_rx_r     <= gnt_rx_s;
      done_tx_r    <= done_tx_s;
      done_rx_r    <= done_rx_s;
      timeout_r    <= timeout_s;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_tx_s    = last_tx_r;
    sb_valid_s   = sb_valid_r;
    sb_message_s = sb_message_r;
    sb_data_s    = sb_data_r;
    gnt_tx_s     = gnt_tx_r;
    gnt_rx_s     = gnt_rx_r;
    done_tx_s    = 1'b0;
    done_rx_s    = 1'b0;
    timeout_s    = 1'b0;

    if (!sb.i_en) begin
      // Abort: everything clears, a coincident busy fall is dropped, the
      // round-robin pointer survives.
      state_s      = ST_IDLE;
      cnt_s        = '0;
      sb_valid_s   = 1'b0;
      sb_message_s = 4'd0;
      sb_data_s    = 3'd0;
      gnt_tx_s     = 1'b0;
      gnt_rx_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sb.i_req_tx || sb.i_req_rx) begin
            state_s    = ST_ISSUE;
            cnt_s      = '0;
            sb_valid_s = 1'b1;
            if (pick_tx_s) begin
              gnt_tx_s     = 1'b1;
              gnt_rx_s     = 1'b0;
              sb_message_s = sb.i_msg_tx;
              sb_data_s    = sb.i_data_tx;
              last_tx_s    = 1'b1;
            end else begin
              gnt_tx_s     = 1'b0;
              gnt_rx_s     = 1'b1;
              sb_message_s = sb.i_msg_rx;
              sb_data_s    = sb.i_data_rx;
              last_tx_s    = 1'b0;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (sb.i_sb_busy) begin
            state_s = ST_WAIT_DONE;
          end else if (cnt_r == TMO_LAST) begin
            // Encoder never picked the message up: give the channel back.
            timeout_s    = 1'b1;
            sb_valid_s   = 1'b0;
            sb_message_s = 4'd0;
            sb_data_s    = 3'd0;
            gnt_tx_s     = 1'b0;
            gnt_rx_s     = 1'b0;
            cnt_s        = '0;
            state_s      = (GAP_CYCLES == 32'd0) ? ST_IDLE : ST_GAP;
          end else begin
            cnt_s = sat_inc(cnt_r);
          end
        end

        ST_WAIT_DONE: begin
          if (busy_fall_s) begin
            done_tx_s    = gnt_tx_r;
            done_rx_s    = gnt_rx_r;
            sb_valid_s   = 1'b0;
            sb_message_s = 4'd0;
            sb_data_s    = 3'd0;
            gnt_tx_s     = 1'b0;
            gnt_rx_s     = 1'b0;
            cnt_s        = '0;
            state_s      = (GAP_CYCLES == 32'd0) ? ST_IDLE : ST_GAP;
          end else begin
            state_s = ST_WAIT_DONE;
          end
        end

        ST_GAP: begin
          if ((GAP_CYCLES == 32'd0) || (cnt_r >= GAP_LAST)) begin
            cnt_s   = '0;
            state_s = ST_IDLE;
          end else begin
            cnt_s = sat_inc(cnt_r);
          end
        end

        default: begin
          state_s      = ST_IDLE;
          cnt_s        = '0;
          sb_valid_s   = 1'b0;
          sb_message_s = 4'd0;
          sb_data_s    = 3'd0;
          gnt_tx_s     = 1'b0;
          gnt_rx_s     = 1'b0;
        end
      endcase
    end
  end

  assign sb.o_sb_valid   = sb_valid_r;
  assign sb.o_sb_message = sb_message_r;
  assign sb.o_sb_data    = sb_data_r;
  assign sb.o_gnt_tx     = gnt_tx_r;
  assign sb.o_gnt_rx     = gnt_rx_r;
  assign sb.o_done_tx    = done_tx_r;
  assign sb.o_done_rx    = done_rx_r;
  assign sb.o_timeout    = timeout_r;

endmodule

// File: tb/tb_repair_sb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_repair_sb_arbiter
// Directed stimulus pushes expected grant/done/timeout events into a queue;
// an independent monitor pops and compares them whenever the DUT shows one.
// ---------------------------------------------------------------------------
module tb_repair_sb_arbiter;

  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_TMO   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] side;   // {tx, rx}
    logic [3:0] msg;
    logic [2:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  ev_t  exp_q[$];
  logic [3:0] cur_msg;
  logic [2:0] cur_data;
  logic       prev_valid;

  repair_sb_arbiter_if bus ();

  repair_sb_arbiter #(
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(64),
    .CNT_W         (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input logic [1:0] kind, input logic [1:0] side,
                                  input logic [3:0] msg, input logic [2:0] data);
    ev_t e;
    e.kind = kind;
    e.side = side;
    e.msg  = msg;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input string name, input logic [1:0] kind, input logic [1:0] side,
                           input logic [3:0] msg, input logic [2:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind=%0d side=%b msg=%h data=%h, none expected",
               name, kind, side, msg, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.side !== side ||
          (kind == EV_GRANT && (e.msg !== msg || e.data !== data))) begin
        errors++;
        $display("FAIL %s: got kind=%0d side=%b msg=%h data=%h expected kind=%0d side=%b msg=%h data=%h",
                 name, kind, side, msg, data, e.kind, e.side, e.msg, e.data);
      end
    end
  endtask

  // Scoreboard monitor
  initial begin
    prev_valid = 1'b0;
    cur_msg    = 4'd0;
    cur_data   = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.o_sb_valid && !prev_valid) begin
          expect_ev("grant", EV_GRANT, {bus.o_gnt_tx, bus.o_gnt_rx},
                    bus.o_sb_message, bus.o_sb_data);
          cur_msg  = bus.o_sb_message;
          cur_data = bus.o_sb_data;
        end else if (bus.o_sb_valid) begin
          chk("msg_hold", {bus.o_sb_message, bus.o_sb_data}, {cur_msg, cur_data});
        end
        if (bus.o_done_tx || bus.o_done_rx)
          expect_ev("done", EV_DONE, {bus.o_done_tx, bus.o_done_rx}, 4'd0, 3'd0);
        if (bus.o_timeout)
          expect_ev("timeout", EV_TMO, {bus.o_gnt_tx, bus.o_gnt_rx}, 4'd0, 3'd0);
        if (bus.o_gnt_tx || bus.o_gnt_rx)
          chk("gnt_onehot", {31'd0, bus.o_gnt_tx & bus.o_gnt_rx}, 32'd0);
        prev_valid = bus.o_sb_valid;
      end
    end
  end

  task automatic chk_idle(input string pfx);
    chk({pfx, "_valid"},   bus.o_sb_valid,   32'd0);
    chk({pfx, "_msg"},     bus.o_sb_message, 32'd0);
    chk({pfx, "_data"},    bus.o_sb_data,    32'd0);
    chk({pfx, "_gnt_tx"},  bus.o_gnt_tx,     32'd0);
    chk({pfx, "_gnt_rx"},  bus.o_gnt_rx,     32'd0);
    chk({pfx, "_done_tx"}, bus.o_done_tx,    32'd0);
    chk({pfx, "_done_rx"}, bus.o_done_rx,    32'd0);
    chk({pfx, "_timeout"}, bus.o_timeout,    32'd0);
  endtask

  // Called while o_sb_valid is low; returns negedges waited until it rises.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.o_sb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.o_sb_valid, 32'd1);
  endtask

  // Sideband side of a transfer: busy rises 2 cycles after valid, high 5 cycles.
  task automatic do_xfer(input logic is_tx, input logic mutate);
    @(negedge clk);
    bus.i_sb_busy = 1'b1;
    @(negedge clk);
    if (mutate) begin
      bus.i_msg_tx  = 4'b1111;
      bus.i_data_tx = 3'b111;
    end
    repeat (4) @(negedge clk);
    push_ev(EV_DONE, is_tx ? 2'b10 : 2'b01, 4'd0, 3'd0);
    bus.i_sb_busy = 1'b0;
    @(negedge clk);
    chk("xfer_done", is_tx ? bus.o_done_tx : bus.o_done_rx, 32'd1);
    chk("xfer_valid_low", bus.o_sb_valid, 32'd0);
    chk("xfer_gnt_low", {bus.o_gnt_tx, bus.o_gnt_rx}, 32'd0);
    chk("xfer_msg_clr", {bus.o_sb_message, bus.o_sb_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_en = 1'b1;
    bus.i_req_tx = 1'b0; bus.i_msg_tx = 4'd0; bus.i_data_tx = 3'd0;
    bus.i_req_rx = 1'b0; bus.i_msg_rx = 4'd0; bus.i_data_rx = 3'd0;
    bus.i_sb_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single tx request
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b0001; bus.i_data_tx = 3'b011;
    push_ev(EV_GRANT, 2'b10, 4'b0001, 3'b011);
    @(negedge clk);
    chk("t1_latency", bus.o_sb_valid, 32'd1);
    chk("t1_msg", {bus.o_sb_message, bus.o_sb_data}, {25'd0, 4'b0001, 3'b011});
    do_xfer(1'b1, 1'b0);
    bus.i_req_tx = 1'b0;
    repeat (4) @(negedge clk);

    // Tie after reset: tx, then rx; tx re-requests at once so rx wins, then tx
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b0010; bus.i_data_tx = 3'b001;
    bus.i_req_rx = 1'b1; bus.i_msg_rx = 4'b1000; bus.i_data_rx = 3'b110;
    push_ev(EV_GRANT, 2'b10, 4'b0010, 3'b001);
    wait_valid("t2_tx_grant", n);
    do_xfer(1'b1, 1'b0);
    bus.i_msg_tx = 4'b0011; bus.i_data_tx = 3'b100;
    push_ev(EV_GRANT, 2'b01, 4'b1000, 3'b110);
    wait_valid("t2_rx_grant", n);
    chk("t2_gap_len", n, 32'd3);
    do_xfer(1'b0, 1'b0);
    bus.i_req_rx = 1'b0;
    push_ev(EV_GRANT, 2'b10, 4'b0011, 3'b100);
    wait_valid("t2_tx2_grant", n);
    do_xfer(1'b1, 1'b1);
    bus.i_req_tx = 1'b0;
    repeat (4) @(negedge clk);

    // Timeout with a pending rx request
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b0100; bus.i_data_tx = 3'b010;
    push_ev(EV_GRANT, 2'b10, 4'b0100, 3'b010);
    wait_valid("t3_grant", n);
    bus.i_req_rx = 1'b1; bus.i_msg_rx = 4'b0101; bus.i_data_rx = 3'b111;
    push_ev(EV_TMO, 2'b00, 4'd0, 3'd0);
    push_ev(EV_GRANT, 2'b01, 4'b0101, 3'b111);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (bus.o_timeout) break;
    end
    chk("t3_timeout_cycle", k, 32'd64);
    chk("t3_valid_low", bus.o_sb_valid, 32'd0);
    chk("t3_gnt_low", bus.o_gnt_tx, 32'd0);
    bus.i_req_tx = 1'b0;
    wait_valid("t3_rx_grant", n);
    chk("t3_gap_len", n, 32'd3);
    do_xfer(1'b0, 1'b0);
    bus.i_req_rx = 1'b0;
    repeat (4) @(negedge clk);

    // Enable drop in WAIT_DONE together with busy fall
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b0110; bus.i_data_tx = 3'b101;
    push_ev(EV_GRANT, 2'b10, 4'b0110, 3'b101);
    wait_valid("t4_grant", n);
    @(negedge clk);
    bus.i_sb_busy = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0; bus.i_sb_busy = 1'b0; bus.i_req_tx = 1'b0;
    @(negedge clk);
    chk_idle("t4_abort");
    @(negedge clk);
    chk("t4_no_done", {bus.o_done_tx, bus.o_done_rx}, 32'd0);
    bus.i_en = 1'b1;
    repeat (2) @(negedge clk);

    // Pointer kept across abort: tie goes to rx; reset in ISSUE; tie goes to tx
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b1001; bus.i_data_tx = 3'b001;
    bus.i_req_rx = 1'b1; bus.i_msg_rx = 4'b0111; bus.i_data_rx = 3'b000;
    push_ev(EV_GRANT, 2'b01, 4'b0111, 3'b000);
    wait_valid("t5_rx_grant", n);
    rst = 1'b1; bus.i_req_tx = 1'b0; bus.i_req_rx = 1'b0;
    @(negedge clk);
    chk_idle("t5_rst");
    rst = 1'b0;
    bus.i_req_tx = 1'b1; bus.i_msg_tx = 4'b1001; bus.i_data_tx = 3'b001;
    bus.i_req_rx = 1'b1; bus.i_msg_rx = 4'b1010; bus.i_data_rx = 3'b010;
    push_ev(EV_GRANT, 2'b10, 4'b1001, 3'b001);
    wait_valid("t5_tx_grant", n);
    do_xfer(1'b1, 1'b0);
    bus.i_req_tx = 1'b0;
    push_ev(EV_GRANT, 2'b01, 4'b1010, 3'b010);
    wait_valid("t5_rx_after", n);
    do_xfer(1'b0, 1'b0);
    bus.i_req_rx = 1'b0;

    repeat (8) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/repair_sb_arbiter.md
Name: repair_sb_arbiter

Overview:
- Shares the single MBTRAIN sideband transmit channel between the REPAIR transmit-side and receive-side sequencers. Both sequencers issue request/response messages with a 3-bit lane encoding, so they need one channel.
- Round-robin grant; the granted message is latched and presented until the sideband completes it (busy falling edge).
- Returns a one-cycle done pulse to the winning requester, then enforces an inter-message gap.
- Sits between the repair sequencers and the sideband encoder.

Parameters:
- GAP_CYCLES, 2, idle cycles after each completion before the next grant (0 allowed = no gap state).
- TIMEOUT_CYCLES, 64, max cycles from valid assertion to busy rising before abort.
- CNT_W, 7, counter width; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_en  in  1  REPAIR substate enable; low = abort and return to IDLE
- i_req_tx  in  1  tx-side requester valid (held until its done)
- i_msg_tx  in  4  tx-side sideband message code
- i_data_tx  in  3  tx-side lane encoding
- i_req_rx  in  1  rx-side requester valid
- i_msg_rx  in  4  rx-side message code
- i_data_rx  in  3  rx-side lane encoding
- i_sb_busy  in  1  sideband encoder busy
- o_sb_valid  out  1  message valid to sideband
- o_sb_message  out  4  granted message
- o_sb_data  out  3  granted lane encoding
- o_gnt_tx  out  1  tx-side currently granted
- o_gnt_rx  out  1  rx-side currently granted
- o_done_tx  out  1  one-cycle pulse: tx-side message sent
- o_done_rx  out  1  one-cycle pulse: rx-side message sent
- o_timeout  out  1  one-cycle pulse: busy never rose

Behaviour:
- Reset (rst=1 at posedge): state IDLE, all outputs 0, busy_q=0, counter 0, last-grant pointer = rx (so tx wins the first tie).
- All outputs are registered. busy_q is i_sb_busy delayed one cycle. busy_fall = busy_q & ~i_sb_busy.
- IDLE:
  - If i_en and any request is present, grant it.
  - If both request, grant the one not granted last; update the pointer.
  - On the grant edge: latch msg/data into o_sb_message/o_sb_data, set o_gnt_x=1 and o_sb_valid=1, clear counter, go ISSUE.
  - Latency: request to o_sb_valid is 1 cycle.
- ISSUE:
  - Hold o_sb_valid=1 and the latched msg/data, ignoring input changes.
  - If i_sb_busy=1, go WAIT_DONE.
  - Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 and busy is still low: o_timeout pulse, o_sb_valid=0, o_gnt_x=0, no done pulse, go GAP.
- WAIT_DONE:
  - On the first busy_fall: o_sb_valid=0, o_gnt_x=0, the matching o_done_x pulses for exactly 1 cycle, o_sb_message/o_sb_data cleared to 0, counter cleared.
  - Then go GAP, or IDLE if GAP_CYCLES=0.
- GAP:
  - Count to GAP_CYCLES-1, then go IDLE.
  - Requests arriving during GAP wait; none are lost because requesters hold valid.
- Requester drops its valid mid-transfer: the transfer still completes and done still pulses. A request that drops while not granted is simply not served.
- Same requester re-requests immediately after its done, while the other also requests: the other wins (round-robin).
- i_en=0 in any state:
  - Next cycle: IDLE, all outputs 0, counter 0. No done or timeout pulse.
  - The pointer is kept.
  - A busy_fall in the same cycle as i_en=0 is ignored.
- rst mid-transfer: identical to reset, and the pointer reinitialises.
- o_gnt_tx and o_gnt_rx are never both 1. o_done_tx and o_done_rx are never both 1.
- Counter saturates and never wraps.

Test Plan:
- Single tx request (msg=0001, data=011); busy rises 2 cycles after valid and is high for 5 cycles -> o_sb_valid/o_sb_message=0001/o_sb_data=011 from cycle+1; o_done_tx pulses 1 cycle after busy falls; o_gnt_tx low afterward.
- Both requesters assert in the same cycle after reset -> tx granted first, rx granted after GAP_CYCLES=2 idle cycles; a repeat tie on the next round -> rx, then tx.
- Busy held low for 64 cycles after grant -> o_timeout pulses at the 64th ISSUE cycle; no done pulse; o_sb_valid drops; a pending request is granted after the gap.
- Requester changes i_msg_tx during WAIT_DONE -> o_sb_message stays at the latched value until done.
- i_en dropped in WAIT_DONE, with busy falling the same cycle -> next cycle all outputs 0, state IDLE, no o_done pulse.
- rst asserted for 1 cycle during ISSUE -> all outputs 0 at the next edge; a subsequent tie grants tx.
